lsu_mem_port: RTL
=================

// Module: lsu_mem_port
// PURPOSE
// - Data-memory load/store unit for the RV32I core. It is the producing end of the writeback Read_data path.
// - Takes one load/store per handshake from the MEM stage and drives a req/gnt/rvalid data-memory bus.
// - Store path: aligns write data and builds byte strobes.
// - Load path: extracts the addressed byte/half/word and sign- or zero-extends it into rsp_rdata.
// - rsp_rdata feeds Result_src=2'b01 of the writeback select.
// PARAMETERS
// - TIMEOUT   16   cycles waiting for mem_gnt or mem_rvalid before aborting with rsp_err; 0 disables the watchdog
// - CNT_W     5    watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
// - clk         in   1   core clock, rising edge
// - rst_n       in   1   asynchronous, active-low reset
// - req_valid   in   1   MEM stage presents an access
// - req_ready   out  1   unit can accept; high only in IDLE
// - req_we      in   1   1=store, 0=load
// - req_funct3  in   3   RV32I funct3: LB/LH/LW/LBU/LHU or SB/SH/SW
// - req_addr    in   32  byte address (ALU_result)
// - req_wdata   in   32  store data (rs2), unaligned
// - rsp_valid   out  1   one-cycle pulse: access finished
// - rsp_rdata   out  32  extended load data, held until next rsp_valid; 0 after a store or error
// - rsp_err     out  1   qualifies rsp_valid: misaligned address or timeout
// - stall       out  1   hazard unit freezes the pipeline; high from accept to rsp_valid inclusive
// - mem_req     out  1   bus request, held until mem_gnt
// - mem_we      out  1   bus write enable
// - mem_addr    out  32  word-aligned address ({req_addr[31:2],2'b00})
// - mem_wstrb   out  4   byte strobes, 0 for loads
// - mem_wdata   out  32  lane-shifted store data
// - mem_gnt     in   1   bus accepts the request this cycle
// - mem_rvalid  in   1   read data valid; at least 1 cycle after gnt
// - mem_rdata   in   32  read word
// BEHAVIOUR
// - Reset state: IDLE. All outputs 0 except req_ready=1. Watchdog counter and captured request are cleared.
// - Reset mid-operation: the access is abandoned and mem_req drops immediately. A later mem_gnt or mem_rvalid seen in IDLE is ignored.
// - FSM states: IDLE, ISSUE, WAIT_R, RESP.
// - IDLE: on req_valid (req_ready=1), register we/funct3/addr/wdata and set stall.
//   - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) goes to RESP with rsp_err=1 and no bus activity.
//   - Any other access goes to ISSUE.
// - ISSUE: mem_req=1 with mem_we/addr/wstrb/wdata stable until gnt.
//   - On gnt, a store goes to RESP and a load goes to WAIT_R.
// - WAIT_R: on mem_rvalid, register the extracted load data and go to RESP.
// - RESP: rsp_valid=1 for exactly one cycle, stall=1, then IDLE. A new request is accepted the following cycle.
// - Store strobes, with a = addr[1:0]:
//   - SB: wstrb = 4'b0001<<a; wdata = {4{rs2[7:0]}}
//   - SH: wstrb = 4'b0011<<a; wdata = {2{rs2[15:0]}}
//   - SW: wstrb = 4'b1111; wdata = rs2
// - Load extraction: byte = rdata[8a+:8]; half = rdata[16*a[1]+:16].
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
// - Latency with zero wait states:
//   - store: accept c0, mem_req c1 (gnt c1), rsp_valid c2
//   - load: rvalid c2, rsp_valid c3
// - Watchdog: counts cycles spent in ISSUE or WAIT_R and restarts on entering each state.
//   - Reaching TIMEOUT goes to RESP with rsp_err=1 and rsp_rdata=0, and drops mem_req.
// - Simultaneous events:
//   - gnt and the watchdog limit in the same cycle: gnt wins.
//   - rvalid in the same cycle as gnt is illegal and ignored.
// - Unsupported funct3 (011, 110, 111): treated as an error with rsp_err=1 and no bus activity.
// STRUCTURE
// - rv32i_pkg holds:
//   - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW
//   - typedef enum logic [1:0] lsu_state_t {IDLE, ISSUE, WAIT_R, RESP}
// - Sub-module lsu_align (combinational): the misaligned check, wstrb/wdata lane shift, and load extract/extend.
// - The FSM, capture registers and watchdog stay in lsu_mem_port.
// TESTING
// - SB, addr=0x103, rs2=0x000000A5, gnt in c1 -> wstrb=4'b1000, wdata=0xA5A5A5A5, mem_addr=0x100, rsp_valid in c2, rsp_err=0
// - LB, addr=0x202, rdata=0x12F34567, rvalid in c2 -> rsp_rdata=0xFFFFFFF3; the same access with LBU -> 0x000000F3
// - LH, addr=0x206, rdata=0x8001BEEF, gnt delayed 3 cycles -> mem_req held 4 cycles, rsp_rdata=0xFFFF8001, stall high throughout
// - LW, addr=0x301 -> no mem_req, rsp_valid+rsp_err the cycle after accept, rsp_rdata=0
// - LW with TIMEOUT=16 and mem_rvalid never asserted -> rsp_err=1 exactly 16 cycles after entering WAIT_R, FSM returns to IDLE
// - rst_n pulsed low while in WAIT_R, then rvalid arrives -> outputs return to reset values at once, the late rvalid is ignored, the next LW completes normally

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings and LSU FSM states.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality, store lane shift/strobes, load extract/extend.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      ofs,
    input  logic [XLEN-1:0] wdata_in,
    input  logic [XLEN-1:0] rdata_in,
    output logic            err_c,
    output logic [3:0]      wstrb_c,
    output logic [XLEN-1:0] wdata_c,
    output logic [XLEN-1:0] rdata_c
);

    logic       supported;
    logic       misaligned;
    logic [7:0] rd_byte;
    logic [15:0] rd_half;

    // Legality: unknown funct3 for the direction, or natural alignment violated
    always_comb begin
        if (we) begin
            supported = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            supported = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                        (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        misaligned = ((funct3[1:0] == 2'b01) && ofs[0]) ||
                     ((funct3[1:0] == 2'b10) && (ofs != 2'b00));
        err_c      = !supported || misaligned;
    end

    // Store lanes: replicate data across the word, strobe only the addressed bytes
    always_comb begin
        wstrb_c = 4'b0000;
        wdata_c = wdata_in;
        if (we) begin
            case (funct3[1:0])
                2'b00: begin
                    wstrb_c = 4'b0001 << ofs;
                    wdata_c = {4{wdata_in[7:0]}};
                end
                2'b01: begin
                    wstrb_c = 4'b0011 << ofs;
                    wdata_c = {2{wdata_in[15:0]}};
                end
                default: begin
                    wstrb_c = 4'b1111;
                    wdata_c = wdata_in;
                end
            endcase
        end
    end

    // Load extract: funct3[2] selects zero-extension over sign-extension
    always_comb begin
        rd_byte = rdata_in[{ofs, 3'b000} +: 8];
        rd_half = rdata_in[{ofs[1], 4'b0000} +: 16];
        case (funct3[1:0])
            2'b00:   rdata_c = {{24{rd_byte[7] & ~funct3[2]}}, rd_byte};
            2'b01:   rdata_c = {{16{rd_half[15] & ~funct3[2]}}, rd_half};
            default: rdata_c = rdata_in;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit: accepts one MEM-stage access, runs it on the req/gnt/rvalid bus.
module lsu_mem_port
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      ofs_q, ofs_d;
    logic            rsp_err_q, rsp_err_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]      mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            req_ready_q, rsp_valid_q, stall_q, mem_req_q;

    logic            al_idle;
    logic            al_err;
    logic [3:0]      al_wstrb;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] al_rdata;
    logic            wd_hit;

    // In IDLE the aligner sees the incoming request, otherwise the captured one
    assign al_idle = (state_q == IDLE);

    lsu_align u_align (
        .we       (al_idle ? req_we         : we_q),
        .funct3   (al_idle ? req_funct3     : funct3_q),
        .ofs      (al_idle ? req_addr[1:0]  : ofs_q),
        .wdata_in (req_wdata),
        .rdata_in (mem_rdata),
        .err_c    (al_err),
        .wstrb_c  (al_wstrb),
        .wdata_c  (al_wdata),
        .rdata_c  (al_rdata)
    );

    // Watchdog limit reached on this cycle; TIMEOUT of 0 never fires
    assign wd_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state, capture and response logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        ofs_d       = ofs_q;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    ofs_d    = req_addr[1:0];
                    cnt_d    = '0;
                    if (al_err) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d     = ISSUE;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                        mem_wstrb_d = al_wstrb;
                        mem_wdata_d = al_wdata;
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    cnt_d = '0;
                    if (we_q) begin
                        state_d     = RESP;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (wd_hit) begin
                    state_d     = RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    state_d     = RESP;
                    rsp_rdata_d = al_rdata;
                end else if (wd_hit) begin
                    state_d     = RESP;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, capture and registered outputs; handshake flags follow the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            ofs_q       <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            stall_q     <= 1'b0;
            mem_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            ofs_q       <= ofs_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            stall_q     <= (state_d != IDLE);
            mem_req_q   <= (state_d == ISSUE);
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign stall     = stall_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule
